fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 64'h100, PC after reset.
REQ-005 SHALL have ports: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: o_mem_req out 1, read request; o_mem_addr out XLEN, word-aligned fetch address.
REQ-007 SHALL have port: i_mem_rdata in ILEN, read data, valid exactly 1 cycle after o_mem_req.
REQ-008 SHALL have ports: i_branch_taken in 1; i_branch_target in XLEN; i_jump in 1; i_jump_target in XLEN.
REQ-009 SHALL have ports: o_valid out 1; o_instr out ILEN; o_pc out XLEN; i_ready in 1 (from ID).
REQ-010 SHALL have port: o_fq_count out $clog2(FQ_DEPTH)+1, current queue occupancy.

Function
REQ-011 SHALL hold fetch_pc; each cycle o_mem_req=1 it SHALL advance fetch_pc by 4.
REQ-012 SHALL track one in-flight bit: set on o_mem_req, response written into queue next cycle with its PC.
REQ-013 SHALL assert o_mem_req only when (count + inflight - pop) < FQ_DEPTH, pop = o_valid & i_ready; sustains 1 instr/cycle for FQ_DEPTH>=2.
REQ-014 SHALL drive o_valid = (count != 0) & ~redirect; o_instr/o_pc from queue head, no bypass of memory data.
REQ-015 SHALL keep o_instr/o_pc stable while o_valid=1 and i_ready=0 (no redirect).
REQ-016 SHALL support simultaneous push and pop; count unchanged, pointers wrap modulo FQ_DEPTH.
REQ-017 SHALL define redirect = i_branch_taken | i_jump; branch SHALL take priority over jump when both assert.
REQ-018 In a redirect cycle SHALL: empty queue at the edge, suppress pop, discard i_mem_rdata arriving that cycle, issue o_mem_req=1 with o_mem_addr = target & ~3, then fetch_pc = (target & ~3) + 4.
REQ-019 SHALL treat redirect as overriding stall (i_ready=0) and full-queue throttle.
REQ-020 Response arriving the cycle after redirect SHALL be kept (belongs to target fetch).
REQ-021 Back-to-back redirects SHALL each apply; latest wins, prior responses discarded.
REQ-022 SHALL never overflow: push with count==FQ_DEPTH is unreachable by REQ-013; bench asserts it.

Reset
REQ-023 While rst=1: o_mem_req=0, o_valid=0, o_fq_count=0, inflight=0, fetch_pc=RESET_PC, redirect inputs ignored.
REQ-024 Reset mid-operation SHALL drop all queued and in-flight data; response arriving in the first cycle after rst falls SHALL be discarded.
REQ-025 First cycle after rst falls: o_mem_req=1, o_mem_addr=RESET_PC; o_valid=1 with o_pc=RESET_PC two cycles later.

Verification
REQ-026 Release reset, i_ready=1 -> o_pc sequence 0x100,0x104,0x108 on consecutive cycles from cycle 2, one per cycle.
REQ-027 i_ready=0 for 10 cycles, FQ_DEPTH=4 -> o_fq_count saturates at 4, o_mem_req=0, o_pc held 0x100; release -> 0x100..0x10C drained in order then 0x110.
REQ-028 Branch to 0x2002 while queue holds 3 entries -> o_valid=0 that cycle, o_mem_addr=0x2000, next valid o_pc=0x2000 two cycles later, no stale PC emitted.
REQ-029 i_branch_taken and i_jump same cycle, targets 0x400/0x800 -> o_mem_addr=0x400, stream continues 0x404.
REQ-030 Assert rst for 1 cycle while queue full and in flight -> all outputs reset per REQ-023, restart at 0x100 per REQ-025.
REQ-031 Random i_ready/redirect for 10k cycles vs reference PC model -> emitted PCs match, no overflow, no lost or duplicated instruction.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a small fetch queue and branch/jump redirect
// One-cycle-latency memory; each request's PC travels with it so queue entries carry their own address.
module fetch_unit #(
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter int               FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h100
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          o_mem_req,
    output logic [XLEN-1:0]               o_mem_addr,
    input  logic [ILEN-1:0]               i_mem_rdata,
    input  logic                          i_branch_taken,
    input  logic [XLEN-1:0]               i_branch_target,
    input  logic                          i_jump,
    input  logic [XLEN-1:0]               i_jump_target,
    output logic                          o_valid,
    output logic [ILEN-1:0]               o_instr,
    output logic [XLEN-1:0]               o_pc,
    input  logic                          i_ready,
    output logic [$clog2(FQ_DEPTH):0]     o_fq_count
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ILEN-1:0]  instr_q [FQ_DEPTH];
    logic [XLEN-1:0]  pc_q    [FQ_DEPTH];

    logic             redirect;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  target_aligned;
    logic             pop;
    logic             push;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic [OCC_W-1:0] occ_after;
    logic             room_ok;

    // Branch wins over jump; redirect inputs are meaningless while in reset.
    assign redirect       = ~rst & (i_branch_taken | i_jump);
    assign target         = i_branch_taken ? i_branch_target : i_jump_target;
    assign target_aligned = target & ~XLEN'(3);

    assign o_valid    = ~rst & (count_q != '0) & ~redirect;
    assign o_instr    = instr_q[rd_ptr_q];
    assign o_pc       = pc_q[rd_ptr_q];
    assign o_fq_count = rst ? '0 : count_q;

    assign pop  = o_valid & i_ready;
    assign push = ~rst & inflight_q & ~redirect;

    // Reserve a slot for the outstanding response before issuing another request.
    assign occ_after = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign room_ok   = occ_after < OCC_W'(FQ_DEPTH);

    assign mem_req    = ~rst & (redirect | room_ok);
    assign mem_addr   = redirect ? target_aligned : fetch_pc_q;
    assign o_mem_req  = mem_req;
    assign o_mem_addr = mem_addr;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = mem_req;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (mem_req) begin
            inflight_pc_d = mem_addr;
            fetch_pc_d    = mem_addr + XLEN'(4);
        end
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= i_mem_rdata;
            pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus randomized run against a queue-level fetch model
module tb_fetch_unit;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int D    = 4;
    localparam logic [63:0] RPC = 64'h100;

    logic            clk = 1'b0;
    logic            rst;
    logic            o_mem_req;
    logic [63:0]     o_mem_addr;
    logic [31:0]     i_mem_rdata;
    logic            i_branch_taken;
    logic [63:0]     i_branch_target;
    logic            i_jump;
    logic [63:0]     i_jump_target;
    logic            o_valid;
    logic [31:0]     o_instr;
    logic [63:0]     o_pc;
    logic            i_ready;
    logic [2:0]      o_fq_count;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .FQ_DEPTH(D), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready),
        .o_fq_count(o_fq_count)
    );

    typedef struct {
        logic        rst, rdy, br;
        logic [63:0] bt;
        logic        jmp;
        logic [63:0] jt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_fail = 0;

    logic        last_req = 1'b0;
    logic [63:0] last_addr = '0;

    logic [63:0] mq[$];
    bit          m_infl = 0;
    logic [63:0] m_infl_pc = '0;
    logic [63:0] m_fetch = RPC;
    logic [63:0] m_next_acc = RPC;
    bit          p_hold = 0;
    logic [63:0] p_hold_pc = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic rdy, input logic br, input logic [63:0] bt,
                                input logic jmp, input logic [63:0] jt, input logic er,
                                input logic [63:0] ea, input logic ev, input logic [63:0] ep, input int ec);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_cnt = ec;
        tbl.push_back(v);
    endfunction

    task automatic model_check();
        logic        redir, pop, e_valid, e_req;
        logic [63:0] tgt;
        int          sz;
        if (rst) begin
            check("rst_req", o_mem_req, 0);
            check("rst_valid", o_valid, 0);
            check("rst_count", o_fq_count, 0);
            mq.delete();
            m_infl = 0; m_fetch = RPC; m_next_acc = RPC; p_hold = 0;
        end else begin
            redir   = i_branch_taken | i_jump;
            tgt     = (i_branch_taken ? i_branch_target : i_jump_target) & ~64'h3;
            sz      = mq.size();
            pop     = (sz != 0) && !redir && i_ready;
            e_valid = (sz != 0) && !redir;
            e_req   = redir || ((sz + int'(m_infl) - int'(pop)) < D);
            check("m_valid", o_valid, e_valid);
            check("m_count", o_fq_count, 64'(sz));
            check("no_overflow", 64'(o_fq_count <= D), 1);
            if (e_valid) begin
                check("m_pc", o_pc, mq[0]);
                check("m_instr", o_instr, mem_word(mq[0]));
            end
            if (p_hold && !redir) begin
                check("hold_valid", o_valid, 1);
                check("hold_pc", o_pc, p_hold_pc);
            end
            check("m_req", o_mem_req, e_req);
            if (e_req) check("m_addr", o_mem_addr, redir ? tgt : m_fetch);
            if (o_valid && i_ready && !redir) begin
                check("seq_pc", o_pc, m_next_acc);
                m_next_acc = o_pc + 64'd4;
            end
            if (redir) m_next_acc = tgt;
            p_hold    = o_valid && !i_ready;
            p_hold_pc = o_pc;
            if (redir) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
            end
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = redir ? tgt : m_fetch;
                m_fetch   = m_infl_pc + 64'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic br, input logic [63:0] bt,
                        input logic jmp, input logic [63:0] jt);
        @(posedge clk);
        #1;
        rst = r; i_ready = rdy;
        i_branch_taken = br; i_branch_target = bt;
        i_jump = jmp; i_jump_target = jt;
        i_mem_rdata = last_req ? mem_word(last_addr) : $urandom;
        @(negedge clk);
        model_check();
        last_req  = o_mem_req;
        last_addr = o_mem_addr;
    endtask

    initial begin
        rst = 1'b1; i_ready = 1'b0; i_branch_taken = 1'b0; i_branch_target = '0;
        i_jump = 1'b0; i_jump_target = '0; i_mem_rdata = '0;

        // Reset, then stall from the first fetch until the queue saturates, then drain.
        add(1,0,0,0,0,0, 0,0,     0,0,     0);
        add(1,0,0,0,0,0, 0,0,     0,0,     0);
        add(0,0,0,0,0,0, 1,'h100, 0,0,     0);
        add(0,0,0,0,0,0, 1,'h104, 0,0,     0);
        add(0,0,0,0,0,0, 1,'h108, 1,'h100, 1);
        add(0,0,0,0,0,0, 1,'h10C, 1,'h100, 2);
        add(0,0,0,0,0,0, 0,0,     1,'h100, 3);
        for (int k = 0; k < 5; k++) add(0,0,0,0,0,0, 0,0, 1,'h100, 4);
        add(0,1,0,0,0,0, 1,'h110, 1,'h100, 4);
        add(0,1,0,0,0,0, 1,'h114, 1,'h104, 3);
        add(0,1,0,0,0,0, 1,'h118, 1,'h108, 3);
        add(0,1,0,0,0,0, 1,'h11C, 1,'h10C, 3);
        add(0,1,0,0,0,0, 1,'h120, 1,'h110, 3);
        // Branch to an unaligned target with three entries queued.
        add(0,1,1,'h2002,0,0, 1,'h2000, 0,0,      3);
        add(0,1,0,0,0,0,      1,'h2004, 0,0,      0);
        add(0,1,0,0,0,0,      1,'h2008, 1,'h2000, 1);
        add(0,1,0,0,0,0,      1,'h200C, 1,'h2004, 1);
        // Branch and jump together: branch target wins.
        add(0,1,1,'h400,1,'h800, 1,'h400, 0,0,     1);
        add(0,1,0,0,0,0,         1,'h404, 0,0,     0);
        add(0,1,0,0,0,0,         1,'h408, 1,'h400, 1);
        add(0,1,0,0,0,0,         1,'h40C, 1,'h404, 1);
        // Fill under stall, reset with a full queue (redirect ignored), restart at RESET_PC.
        add(0,0,0,0,0,0, 1,'h410, 1,'h408, 1);
        add(0,0,0,0,0,0, 1,'h414, 1,'h408, 2);
        add(0,0,0,0,0,0, 0,0,     1,'h408, 3);
        add(0,0,0,0,0,0, 0,0,     1,'h408, 4);
        add(1,1,1,'h3000,0,0, 0,0, 0,0, 0);
        add(0,1,0,0,0,0, 1,'h100, 0,0,     0);
        add(0,1,0,0,0,0, 1,'h104, 0,0,     0);
        add(0,1,0,0,0,0, 1,'h108, 1,'h100, 1);
        add(0,1,0,0,0,0, 1,'h10C, 1,'h104, 1);
        // Back-to-back redirects: the later one wins.
        add(0,1,0,0,1,'h500, 1,'h500, 0,0,     1);
        add(0,1,1,'h600,0,0, 1,'h600, 0,0,     0);
        add(0,1,0,0,0,0,     1,'h604, 0,0,     0);
        add(0,1,0,0,0,0,     1,'h608, 1,'h600, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt);
            check($sformatf("v%0d_req", i), o_mem_req, tbl[i].e_req);
            if (tbl[i].e_req) check($sformatf("v%0d_addr", i), o_mem_addr, tbl[i].e_addr);
            check($sformatf("v%0d_valid", i), o_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) check($sformatf("v%0d_pc", i), o_pc, tbl[i].e_pc);
            check($sformatf("v%0d_count", i), o_fq_count, 64'(tbl[i].e_cnt));
        end

        for (int c = 0; c < 10000; c++) begin
            logic        r, rdy, br, jmp;
            logic [63:0] bt, jt;
            r   = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) == 0);
            jmp = ($urandom_range(0, 19) == 0);
            bt  = {$urandom, $urandom};
            jt  = {$urandom, $urandom};
            step(r, rdy, br, bt, jmp, jt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
